data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 10, word address width; DATA_W, 32, data width.
REQ-002 clock  in  1  single clock; all state updates on posedge clock.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 cpu_req / cpu_we  in  1 / 1  CPU access request, held until acknowledged / write (1) or read (0).
REQ-005 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address / write data.
REQ-006 cpu_ack / cpu_rdata  out  1 / DATA_W  access-complete pulse / read data, valid while cpu_ack=1.
REQ-007 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  SHALL mirror the CPU port for the UART debug requester.
REQ-008 dbg_burst_start  in  1  one-cycle pulse starting a sequential read burst at dbg_addr.
REQ-009 dbg_burst_len  in  ADDR_W+1  burst word count; 0 means 1024.
REQ-010 dbg_ready / dbg_rvalid / dbg_burst_done  in / out / out  1 each  burst sink ready / burst word valid on dbg_rdata / last-word-accepted pulse.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 mem_address / mem_data_write / mem_write  out  ADDR_W / DATA_W / 1  registered memory drive.
REQ-013 mem_data_read  in  DATA_W  memory read data, updated by memory on negedge clock.

Function
REQ-014 States SHALL be IDLE, ACCESS, ACK, BURST_RD, BURST_OUT.
REQ-015 In IDLE, a pending request SHALL be granted at the posedge: drive mem_address, mem_data_write, mem_write=we of winner; go to ACCESS.
REQ-016 ACCESS -> ACK at next posedge; on a read, winner's rdata SHALL capture mem_data_read at that edge; winner's ack=1 for exactly the ACK cycle; mem_write SHALL return to 0 entering ACK.
REQ-017 ACK -> IDLE unconditionally with no arbitration (requester drops req after sampling ack); request-to-ack latency 2 cycles, throughput 1 access per 3 cycles.
REQ-018 Arbitration SHALL be round-robin: on CPU/debug tie, the requester not granted last wins; single requester wins outright.
REQ-019 dbg_burst_start SHALL count as a debug request and take precedence over dbg_req in the same cycle; outside IDLE it SHALL be ignored.
REQ-020 Burst: latch base=dbg_addr, remaining=len (0->1024); BURST_RD drives mem_address=current address, mem_write=0; next posedge captures mem_data_read into dbg_rdata, -> BURST_OUT.
REQ-021 BURST_OUT: dbg_rvalid=1, dbg_rdata stable until dbg_ready=1 at a posedge; then decrement remaining, increment address modulo 2^ADDR_W (1023 -> 0), -> BURST_RD, or -> IDLE with dbg_burst_done pulsed one cycle if remaining was 1.
REQ-022 CPU requests during a burst SHALL stall (no cpu_ack) and be served after burst end per round-robin.
REQ-023 Only one ack/rvalid output SHALL be high in any cycle; mem_write SHALL never be high outside ACCESS.

Reset
REQ-024 At reset: state IDLE; mem_address, mem_data_write, cpu_rdata, dbg_rdata = 0; mem_write, cpu_ack, dbg_ack, dbg_rvalid, dbg_burst_done, busy = 0; last-grant = debug (CPU wins first tie).
REQ-025 Reset mid-access or mid-burst SHALL abort immediately; no ack or rvalid issued for the aborted transaction.

Configuration
REQ-026 Macro DMEM_ARB_BURST_EN SHALL compile in burst logic (BURST_RD, BURST_OUT, counters).
REQ-027 Without DMEM_ARB_BURST_EN: dbg_burst_start and dbg_ready ignored, dbg_rvalid and dbg_burst_done tied 0, states BURST_* absent.

Verification
REQ-028 CPU read addr 5 (memory holds 5) -> mem_write=0, cpu_ack 2 cycles after req, cpu_rdata=5.
REQ-029 CPU write 0xDEADBEEF to 17, then dbg read 17 -> mem_write=1 one cycle only; dbg_rdata=0xDEADBEEF.
REQ-030 cpu_req and dbg_req asserted together from reset, held -> grants CPU, debug, CPU alternating.
REQ-031 Burst base 1022, len 4, dbg_ready toggling -> words 1022,1023,0,1 in order, each held until ready; dbg_burst_done once after 4th.
REQ-032 Reset asserted during ACCESS of a write -> next cycle mem_write=0, no ack, state IDLE, busy=0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - CPU/debug requester ports and memory drive bundle for data_mem_arbiter
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_burst_start;
    logic [ADDR_W:0]   dbg_burst_len;
    logic              dbg_ready;
    logic              dbg_rvalid;
    logic              dbg_burst_done;

    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_write;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_read;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_burst_start, dbg_burst_len, dbg_ready,
        output dbg_ack, dbg_rdata, dbg_rvalid, dbg_burst_done,
        output busy, mem_address, mem_data_write, mem_write,
        input  mem_data_read
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_burst_start, dbg_burst_len, dbg_ready,
        input  dbg_ack, dbg_rdata, dbg_rvalid, dbg_burst_done,
        input  busy, mem_address, mem_data_write, mem_write,
        output mem_data_read
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin CPU/debug data memory arbiter; DMEM_ARB_BURST_EN adds debug read bursts
module data_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    data_mem_arbiter_if.slave bus
);

`ifdef DMEM_ARB_BURST_EN
    typedef enum logic [2:0] {IDLE, ACCESS, ACK, BURST_RD, BURST_OUT} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
`endif

    state_t            r_state;
    logic              r_last_dbg;
    logic              r_grant_dbg;
    logic              r_grant_we;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data_write;
    logic              r_mem_write;
    logic              r_cpu_ack;
    logic              r_dbg_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_busy;
    logic              w_dbg_pend;
    logic              w_win_dbg;

`ifdef DMEM_ARB_BURST_EN
    logic [ADDR_W-1:0] r_burst_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_rvalid;
    logic              r_done;

    assign w_dbg_pend         = bus.dbg_req | bus.dbg_burst_start;
    assign bus.dbg_rvalid     = r_rvalid;
    assign bus.dbg_burst_done = r_done;
`else
    logic w_unused;

    assign w_dbg_pend         = bus.dbg_req;
    assign w_unused           = ^{bus.dbg_burst_start, bus.dbg_ready, bus.dbg_burst_len};
    assign bus.dbg_rvalid     = 1'b0;
    assign bus.dbg_burst_done = 1'b0;
`endif

    // On a tie the requester that was not served last wins.
    assign w_win_dbg = w_dbg_pend & (~bus.cpu_req | ~r_last_dbg);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= IDLE;
            r_last_dbg       <= 1'b1;
            r_grant_dbg      <= 1'b0;
            r_grant_we       <= 1'b0;
            r_mem_address    <= '0;
            r_mem_data_write <= '0;
            r_mem_write      <= 1'b0;
            r_cpu_ack        <= 1'b0;
            r_dbg_ack        <= 1'b0;
            r_cpu_rdata      <= '0;
            r_dbg_rdata      <= '0;
            r_busy           <= 1'b0;
`ifdef DMEM_ARB_BURST_EN
            r_burst_addr     <= '0;
            r_remaining      <= '0;
            r_rvalid         <= 1'b0;
            r_done           <= 1'b0;
`endif
        end else begin
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
`ifdef DMEM_ARB_BURST_EN
            r_done    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (bus.cpu_req | w_dbg_pend) begin
                        r_last_dbg <= w_win_dbg;
                        r_busy     <= 1'b1;
`ifdef DMEM_ARB_BURST_EN
                        if (w_win_dbg & bus.dbg_burst_start) begin
                            r_burst_addr  <= bus.dbg_addr;
                            r_remaining   <= (bus.dbg_burst_len == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                                       : bus.dbg_burst_len;
                            r_mem_address <= bus.dbg_addr;
                            r_mem_write   <= 1'b0;
                            r_state       <= BURST_RD;
                        end else
`endif
                        begin
                            r_grant_dbg      <= w_win_dbg;
                            r_grant_we       <= w_win_dbg ? bus.dbg_we : bus.cpu_we;
                            r_mem_address    <= w_win_dbg ? bus.dbg_addr : bus.cpu_addr;
                            r_mem_data_write <= w_win_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                            r_mem_write      <= w_win_dbg ? bus.dbg_we : bus.cpu_we;
                            r_state          <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    r_mem_write <= 1'b0;
                    r_state     <= ACK;
                    if (r_grant_dbg) begin
                        r_dbg_ack <= 1'b1;
                        if (!r_grant_we) r_dbg_rdata <= bus.mem_data_read;
                    end else begin
                        r_cpu_ack <= 1'b1;
                        if (!r_grant_we) r_cpu_rdata <= bus.mem_data_read;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
`ifdef DMEM_ARB_BURST_EN
                BURST_RD: begin
                    r_dbg_rdata <= bus.mem_data_read;
                    r_rvalid    <= 1'b1;
                    r_state     <= BURST_OUT;
                end
                BURST_OUT: begin
                    if (bus.dbg_ready) begin
                        r_rvalid     <= 1'b0;
                        r_remaining  <= r_remaining - (ADDR_W+1)'(1);
                        r_burst_addr <= r_burst_addr + ADDR_W'(1);
                        if (r_remaining == (ADDR_W+1)'(1)) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_mem_address <= r_burst_addr + ADDR_W'(1);
                            r_state       <= BURST_RD;
                        end
                    end
                end
`endif
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_ack        = r_cpu_ack;
    assign bus.cpu_rdata      = r_cpu_rdata;
    assign bus.dbg_ack        = r_dbg_ack;
    assign bus.dbg_rdata      = r_dbg_rdata;
    assign bus.busy           = r_busy;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_data_write = r_mem_data_write;
    assign bus.mem_write      = r_mem_write;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized self-checking bench for data_mem_arbiter with a transaction-level model
module tb_data_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check_w(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Memory device: writes at posedge, read data refreshed on negedge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) if (bus.mem_write === 1'b1) mem[bus.mem_address] <= bus.mem_data_write;
    always @(negedge clock) bus.mem_data_read <= mem[bus.mem_address];

    // Transaction model: a grant at cycle t means write strobe in cycle t, ack in t+1, free again at t+3.
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            cyc      = 0;
    int            t_grant  = -10;
    bit            last_dbg = 1'b1;
    bit            model_on = 1'b0;
    bit            g_dbg, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, g_rd;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            t_grant  = cyc - 3;
            last_dbg = 1'b1;
        end else if ((cyc - t_grant) >= 3 && (bus.cpu_req || bus.dbg_req)) begin
            if (bus.cpu_req && bus.dbg_req) g_dbg = !last_dbg;
            else                            g_dbg = bus.dbg_req;
            last_dbg = g_dbg;
            t_grant  = cyc;
            g_we     = g_dbg ? bus.dbg_we    : bus.cpu_we;
            g_addr   = g_dbg ? bus.dbg_addr  : bus.cpu_addr;
            g_wdata  = g_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            if (g_we) shadow[g_addr] = g_wdata;
            else      g_rd = shadow[g_addr];
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            int age;
            age = cyc - t_grant;
            check_b("m_busy", bus.busy, (age == 0) || (age == 1));
            check_b("m_mem_write", bus.mem_write, (age == 0) && g_we);
            check_b("m_cpu_ack", bus.cpu_ack, (age == 1) && !g_dbg);
            check_b("m_dbg_ack", bus.dbg_ack, (age == 1) && g_dbg);
            check_b("m_rvalid", bus.dbg_rvalid, 1'b0);
            check_b("m_burst_done", bus.dbg_burst_done, 1'b0);
            if (age == 0) check_w("m_mem_address", 32'(bus.mem_address), 32'(g_addr));
            if (age == 0 && g_we) check_w("m_mem_wdata", bus.mem_data_write, g_wdata);
            if (age == 1 && !g_we) check_w("m_rdata", g_dbg ? bus.dbg_rdata : bus.cpu_rdata, g_rd);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_access(input bit dbg, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, output int lat, output int wcyc,
                             output logic [DW-1:0] rd);
        lat  = 0;
        wcyc = 0;
        if (dbg) begin
            bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd; bus.dbg_req = 1'b1;
        end else begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_req = 1'b1;
        end
        while (lat < 20) begin
            tick();
            lat++;
            if (bus.mem_write) wcyc++;
            if (dbg ? bus.dbg_ack : bus.cpu_ack) break;
        end
        rd = dbg ? bus.dbg_rdata : bus.cpu_rdata;
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        tick();
        if (bus.mem_write) wcyc++;
    endtask

    int            lat, wcyc, g;
    logic [DW-1:0] rd;
    bit            seq [0:3];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = DW'(i);
            shadow[i] = DW'(i);
        end
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.dbg_burst_start = 0; bus.dbg_burst_len = '0; bus.dbg_ready = 0;

        repeat (2) tick();
        model_on = 1'b1;
        check_b("rst_busy", bus.busy, 1'b0);
        check_b("rst_mem_write", bus.mem_write, 1'b0);
        check_b("rst_cpu_ack", bus.cpu_ack, 1'b0);
        check_b("rst_dbg_ack", bus.dbg_ack, 1'b0);
        check_b("rst_rvalid", bus.dbg_rvalid, 1'b0);
        check_b("rst_done", bus.dbg_burst_done, 1'b0);
        check_w("rst_mem_address", 32'(bus.mem_address), 32'd0);
        check_w("rst_mem_wdata", bus.mem_data_write, 32'd0);
        check_w("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check_w("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
        reset = 1'b0;

        do_access(1'b0, 1'b0, 10'd5, 32'd0, lat, wcyc, rd);
        check_w("rd5_latency", lat, 2);
        check_w("rd5_write_cycles", wcyc, 0);
        check_w("rd5_data", rd, 32'd5);

        do_access(1'b0, 1'b1, 10'd17, 32'hDEADBEEF, lat, wcyc, rd);
        check_w("wr17_latency", lat, 2);
        check_w("wr17_write_cycles", wcyc, 1);
        do_access(1'b1, 1'b0, 10'd17, 32'd0, lat, wcyc, rd);
        check_w("dbg_rd17_latency", lat, 2);
        check_w("dbg_rd17_data", rd, 32'hDEADBEEF);

        reset = 1'b1; tick(); reset = 1'b0;
        bus.cpu_we = 0; bus.cpu_addr = 10'd3; bus.dbg_we = 0; bus.dbg_addr = 10'd4;
        bus.cpu_req = 1'b1; bus.dbg_req = 1'b1;
        g = 0;
        for (int i = 0; i < 40 && g < 4; i++) begin
            tick();
            if (!bus.cpu_req) bus.cpu_req = 1'b1;
            if (!bus.dbg_req) bus.dbg_req = 1'b1;
            if (bus.cpu_ack) begin
                seq[g] = 1'b0; g++; bus.cpu_req = 1'b0;
            end else if (bus.dbg_ack) begin
                seq[g] = 1'b1; g++; bus.dbg_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
        repeat (2) tick();
        check_w("rr_grant_count", g, 4);
        for (int i = 0; i < 4; i++) check_b("rr_order", seq[i], (i % 2) == 1);

        bus.cpu_we = 1'b1; bus.cpu_addr = 10'd40; bus.cpu_wdata = 32'h12345678; bus.cpu_req = 1'b1;
        tick();
        check_b("abort_write_in_access", bus.mem_write, 1'b1);
        reset = 1'b1;
        tick();
        check_b("abort_mem_write", bus.mem_write, 1'b0);
        check_b("abort_busy", bus.busy, 1'b0);
        check_b("abort_cpu_ack", bus.cpu_ack, 1'b0);
        reset = 1'b0; bus.cpu_req = 1'b0;
        tick();
        check_b("abort_no_late_ack", bus.cpu_ack, 1'b0);
        check_b("abort_idle", bus.busy, 1'b0);

`ifdef DMEM_ARB_BURST_EN
        begin
            logic [DW-1:0] held;
            logic [DW-1:0] exp_words [0:3];
            int nwords, accepted, ndone;
            bit prev_v, prev_r;
            exp_words[0] = 32'd1022; exp_words[1] = 32'd1023;
            exp_words[2] = 32'd0;    exp_words[3] = 32'd1;
            model_on = 1'b0;
            nwords = 0; accepted = 0; ndone = 0; prev_v = 0; prev_r = 0; held = '0;
            bus.dbg_addr = 10'd1022; bus.dbg_burst_len = 11'd4; bus.dbg_ready = 1'b0;
            bus.dbg_burst_start = 1'b1;
            tick();
            bus.dbg_burst_start = 1'b0;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (prev_v && prev_r) accepted++;
                if (bus.dbg_burst_done) begin
                    ndone++;
                    check_w("burst_done_after_last", accepted, 4);
                end
                if (bus.dbg_rvalid) begin
                    if (!prev_v || prev_r) begin
                        if (nwords < 4) check_w("burst_word", bus.dbg_rdata, exp_words[nwords]);
                        nwords++;
                        held = bus.dbg_rdata;
                    end else begin
                        check_w("burst_hold", bus.dbg_rdata, held);
                    end
                end
                bus.dbg_ready = ~bus.dbg_ready;
                prev_v = bus.dbg_rvalid;
                prev_r = bus.dbg_ready;
            end
            check_w("burst_word_count", nwords, 4);
            check_w("burst_done_count", ndone, 1);
            check_b("burst_end_idle", bus.busy, 1'b0);
            bus.dbg_ready = 1'b0;
            reset = 1'b1; tick(); reset = 1'b0;
            model_on = 1'b1;
        end
`else
        bus.dbg_addr = 10'd7; bus.dbg_burst_len = 11'd3; bus.dbg_ready = 1'b1;
        bus.dbg_burst_start = 1'b1;
        tick();
        bus.dbg_burst_start = 1'b0;
        check_b("nob_rvalid", bus.dbg_rvalid, 1'b0);
        tick();
        check_b("nob_busy", bus.busy, 1'b0);
        check_b("nob_rvalid2", bus.dbg_rvalid, 1'b0);
        bus.dbg_ready = 1'b0;
`endif

        for (int i = 0; i < 1500; i++) begin
            tick();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 99) == 0) reset = 1'b1;
            if (bus.cpu_req && bus.cpu_ack) bus.cpu_req = 1'b0;
            else if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                bus.cpu_wdata = $urandom;
                bus.cpu_req   = 1'b1;
            end
            if (bus.dbg_req && bus.dbg_ack) bus.dbg_req = 1'b0;
            else if (!bus.dbg_req && $urandom_range(0, 2) == 0) begin
                bus.dbg_we    = 1'($urandom_range(0, 1));
                bus.dbg_addr  = AW'($urandom_range(0, 15));
                bus.dbg_wdata = $urandom;
                bus.dbg_req   = 1'b1;
            end
        end
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0; reset = 1'b0;
        repeat (4) tick();
        model_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
